// File: rtl/p4_adder_arbiter.sv
// -----------------------------------------------------------------------------
// p4_adder_arbiter
//
// Round-robin front end for one shared combinational P4 sparse-tree adder.
// NREQ requesters each present an (a, b, cin) triple on a valid/ready
// handshake. The granted triple is steered onto the adder, and the adder's
// sum/carry-out are captured into a single-entry response register that is
// tagged with the requester index.
//
// Ports:
//   clk, rst_n            clock; asynchronous active-low reset
//   req_valid[NREQ]       per-requester request
//   req_ready[NREQ]       per-requester accept (at most one bit high)
//   req_a, req_b          packed operands, requester i in [i*WIDTH +: WIDTH]
//   req_cin[NREQ]         per-requester carry-in
//   add_a, add_b, add_cin operands driven to the external adder
//   add_s, add_cout       combinational result from the external adder
//   resp_valid/ready      response handshake
//   resp_id, resp_s,
//   resp_cout             registered response payload
// -----------------------------------------------------------------------------
module p4_adder_arbiter #(
    parameter int   NREQ  = 4,
    parameter int   WIDTH = 32,
    localparam int  ID_W  = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]       req_cin,
    output logic [WIDTH-1:0]      add_a,
    output logic [WIDTH-1:0]      add_b,
    output logic                  add_cin,
    input  logic [WIDTH-1:0]      add_s,
    input  logic                  add_cout,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [ID_W-1:0]       resp_id,
    output logic [WIDTH-1:0]      resp_s,
    output logic                  resp_cout
);

    // State
    logic [ID_W-1:0]  ptr_q,        ptr_d;
    logic             resp_valid_q, resp_valid_d;
    logic [ID_W-1:0]  resp_id_q,    resp_id_d;
    logic [WIDTH-1:0] resp_s_q,     resp_s_d;
    logic             resp_cout_q,  resp_cout_d;

    // Unpacked views of the packed operand buses
    logic [WIDTH-1:0] a_arr [NREQ];
    logic [WIDTH-1:0] b_arr [NREQ];

    logic             grant_found;
    logic [ID_W-1:0]  grant_idx;
    logic [NREQ-1:0]  grant_oh;
    logic             can_accept;
    logic             transfer;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign a_arr[gi]    = req_a[gi*WIDTH +: WIDTH];
            assign b_arr[gi]    = req_b[gi*WIDTH +: WIDTH];
            assign grant_oh[gi] = grant_found && (grant_idx == ID_W'(gi));
        end
    endgenerate

    // Rotating priority search starting at ptr_q. Depends only on req_valid
    // and ptr_q, so the operand buses never reach req_ready combinationally.
    always_comb begin : grant_search
        int unsigned idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr_q) + k) % NREQ;
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = idx[ID_W-1:0];
            end
        end
    end

    assign can_accept = !resp_valid_q || resp_ready;
    // rst_n gating keeps req_ready low for the whole time reset is held.
    assign req_ready  = grant_oh & {NREQ{can_accept && rst_n}};
    assign transfer   = |(req_valid & req_ready);

    // Operands follow the grant even under backpressure; zero when idle.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (grant_found) begin
            add_a   = a_arr[grant_idx];
            add_b   = b_arr[grant_idx];
            add_cin = req_cin[grant_idx];
        end
    end

    always_comb begin
        ptr_d        = ptr_q;
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        resp_s_d     = resp_s_q;
        resp_cout_d  = resp_cout_q;
        if (transfer) begin
            // Also covers drain-and-accept in the same cycle: overwrite.
            resp_valid_d = 1'b1;
            resp_id_d    = grant_idx;
            resp_s_d     = add_s;
            resp_cout_d  = add_cout;
            if (grant_idx == ID_W'(NREQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_idx + ID_W'(1);
            end
        end else if (resp_ready) begin
            resp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_s_q     <= '0;
            resp_cout_q  <= 1'b0;
        end else begin
            ptr_q        <= ptr_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_s_q     <= resp_s_d;
            resp_cout_q  <= resp_cout_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_s     = resp_s_q;
    assign resp_cout  = resp_cout_q;

endmodule

// File: tb/tb_p4_adder_arbiter.sv
// -----------------------------------------------------------------------------
// tb_p4_adder_arbiter
//
// Directed test of p4_adder_arbiter with NREQ=4, WIDTH=32. A behavioural
// adder closes the loop between add_* and add_s/add_cout. Inputs change on
// the falling edge; combinational outputs are checked 1 time unit later,
// registered outputs 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_p4_adder_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 32;
    localparam int ID_W  = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_cin;
    logic [WIDTH-1:0]      add_a;
    logic [WIDTH-1:0]      add_b;
    logic                  add_cin;
    logic [WIDTH-1:0]      add_s;
    logic                  add_cout;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [ID_W-1:0]       resp_id;
    logic [WIDTH-1:0]      resp_s;
    logic                  resp_cout;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    // Behavioural stand-in for the shared adder.
    assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};

    p4_adder_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_cin    (req_cin),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_cin    (add_cin),
        .add_s      (add_s),
        .add_cout   (add_cout),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_s     (resp_s),
        .resp_cout  (resp_cout)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic c);
        req_a[i*WIDTH +: WIDTH] = a;
        req_b[i*WIDTH +: WIDTH] = b;
        req_cin[i]              = c;
    endtask

    task automatic chk_resp(input string tag, input logic v, input logic [ID_W-1:0] id,
                            input logic [31:0] s, input logic co);
        chk({tag, ".valid"}, 64'(resp_valid), 64'(v));
        chk({tag, ".id"},    64'(resp_id),    64'(id));
        chk({tag, ".s"},     64'(resp_s),     64'(s));
        chk({tag, ".cout"},  64'(resp_cout),  64'(co));
        $display("step %-10s resp_valid=%0b id=%0d s=0x%08h cout=%0b", tag, resp_valid, resp_id, resp_s, resp_cout);
    endtask

    task automatic rise();
        @(posedge clk);
        #1;
    endtask

    task automatic fall();
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] exp_s [NREQ];
        rst_n      = 1'b0;
        req_valid  = 4'b1111;
        req_a      = '0;
        req_b      = '0;
        req_cin    = '0;
        resp_ready = 1'b0;

        // ---- Reset state ----------------------------------------------------
        rise(); rise();
        chk("rst.ready", 64'(req_ready), 64'h0);
        chk_resp("rst", 1'b0, 2'd0, 32'h0, 1'b0);

        fall();
        req_valid = 4'b0000;
        rst_n     = 1'b1;
        #1;
        chk("idle.add_a", 64'(add_a), 64'h0);

        // ---- Single request: FFFFFFFF + 1 -> 0, cout 1 ----------------------
        fall();
        set_op(2, 32'hFFFF_FFFF, 32'h1, 1'b0);
        req_valid  = 4'b0100;
        resp_ready = 1'b1;
        #1;
        chk("single.ready", 64'(req_ready), 64'b0100);
        chk("single.add_a", 64'(add_a), 64'hFFFF_FFFF);
        rise();
        chk_resp("single", 1'b1, 2'd2, 32'h0000_0000, 1'b1);

        // ---- Wrap-around from ptr=3, carry-in path --------------------------
        fall();
        set_op(3, 32'h7FFF_FFFF, 32'h0, 1'b1);
        set_op(0, 32'd10, 32'd20, 1'b0);
        req_valid = 4'b1001;
        #1;
        chk("wrap.ready", 64'(req_ready), 64'b1000);
        rise();
        chk_resp("wrap3", 1'b1, 2'd3, 32'h8000_0000, 1'b0);

        // ---- Backpressure: 0 and 1 pending, response held -------------------
        fall();
        set_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        req_valid  = 4'b0011;
        resp_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp.ready", 64'(req_ready), 64'h0);
            chk("bp.add_a", 64'(add_a), 64'd10);
            rise();
            chk_resp("bp.hold", 1'b1, 2'd3, 32'h8000_0000, 1'b0);
            fall();
        end
        resp_ready = 1'b1;
        #1;
        chk("bp.release", 64'(req_ready), 64'b0001);
        rise();
        chk_resp("bp.acc0", 1'b1, 2'd0, 32'h0000_001E, 1'b0);

        fall();
        req_valid = 4'b0010;
        #1;
        chk("bp.ready1", 64'(req_ready), 64'b0010);
        rise();
        chk_resp("bp.acc1", 1'b1, 2'd1, 32'hFFFF_FFFF, 1'b1);

        fall();
        req_valid = 4'b0000;
        rise();
        chk_resp("drain", 1'b0, 2'd1, 32'hFFFF_FFFF, 1'b1);

        // ---- Reset mid-operation --------------------------------------------
        fall();
        set_op(2, 32'd1, 32'd2, 1'b0);
        req_valid = 4'b0100;
        rise();
        chk_resp("pre_rst", 1'b1, 2'd2, 32'd3, 1'b0);
        fall();
        req_valid  = 4'b0000;
        resp_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_resp("async_rst", 1'b0, 2'd0, 32'h0, 1'b0);
        fall();
        set_op(1, 32'h1234_5678, 32'h1111_1111, 1'b0);
        set_op(3, 32'h8000_0000, 32'h8000_0000, 1'b0);
        req_valid  = 4'b1010;
        resp_ready = 1'b1;
        #1;
        chk("rst_hold.ready", 64'(req_ready), 64'h0);
        fall();
        rst_n = 1'b1;
        #1;
        chk("post_rst.ready", 64'(req_ready), 64'b0010);
        rise();
        chk_resp("post_rst1", 1'b1, 2'd1, 32'h2345_6789, 1'b0);
        fall();
        req_valid = 4'b1000;
        #1;
        chk("post_rst.ready3", 64'(req_ready), 64'b1000);
        rise();
        chk_resp("post_rst3", 1'b1, 2'd3, 32'h0000_0000, 1'b1);

        // ---- Full contention from ptr=0: grants 0,1,2,3,0 -------------------
        fall();
        set_op(0, 32'h0000_0000, 32'd0, 1'b0);
        set_op(1, 32'h0000_0100, 32'd1, 1'b1);
        set_op(2, 32'h0000_0200, 32'd2, 1'b0);
        set_op(3, 32'h0000_0300, 32'd3, 1'b1);
        exp_s[0] = 32'h0000_0000;
        exp_s[1] = 32'h0000_0102;
        exp_s[2] = 32'h0000_0202;
        exp_s[3] = 32'h0000_0304;
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            int g;
            g = k % NREQ;
            #1;
            chk("rr.ready", 64'(req_ready), 64'(1 << g));
            rise();
            chk_resp("rr", 1'b1, g[ID_W-1:0], exp_s[g], 1'b0);
            fall();
        end
        req_valid = 4'b0000;
        rise();
        chk("end.valid", 64'(resp_valid), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
